// File: rtl/int_decode_stage.sv
// int_decode_stage: RV32I integer/jump/upper-immediate decode feeding the execute ALU,
// with a registered valid/ready output and a one-entry skid so fetch never sees exReady combinationally.
package int_decode_pkg;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_JUMP = 4'd10;
    localparam logic [3:0] ALU_NONE = 4'd15;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
endpackage

module int_decode_stage
    import int_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            flush,
    input  logic            ifValid,
    output logic            ifReady,
    input  logic [XLEN-1:0] ifPc,
    input  logic [31:0]     ifInsn,
    output logic [4:0]      rs1Addr,
    output logic [4:0]      rs2Addr,
    input  logic [XLEN-1:0] rs1Data,
    input  logic [XLEN-1:0] rs2Data,
    output logic            exValid,
    input  logic            exReady,
    output logic [3:0]      exAlucode,
    output logic [XLEN-1:0] exOp1,
    output logic [XLEN-1:0] exOp2,
    output logic [4:0]      exRd,
    output logic            exRegWrite,
    output logic            exIllegal
);
    typedef struct packed {
        logic [3:0]      alucode;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            illegal;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{alucode: ALU_NONE, default: '0};

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_u;
    logic            is_shift, alt, f7_ok_op, f7_ok_shift;
    logic [3:0]      f3_code;
    entry_t          dec, main_q, skid_q;
    logic            main_valid, skid_valid, in_fire, out_fire, main_free;

    assign opcode  = ifInsn[6:0];
    assign funct3  = ifInsn[14:12];
    assign funct7  = ifInsn[31:25];
    assign rs1Addr = ifInsn[19:15];
    assign rs2Addr = ifInsn[24:20];
    assign imm_i   = {{(XLEN-12){ifInsn[31]}}, ifInsn[31:20]};
    assign imm_u   = {ifInsn[31:12], 12'b0};
    assign is_shift = funct3[1:0] == 2'b01;
    // insn[30] only selects SUB/SRA for register ops and immediate shifts; addi reuses it as an imm bit
    assign alt = funct7[5] && (opcode == OPC_OP || is_shift);
    assign f7_ok_op = funct7 == 7'b0 || (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
    assign f7_ok_shift = funct7 == 7'b0 || (funct7 == 7'b0100000 && funct3 == 3'b101);

    always_comb begin
        f3_code = ALU_ADD;
        case (funct3)
            3'b000:  f3_code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  f3_code = ALU_SLL;
            3'b010:  f3_code = ALU_SLT;
            3'b011:  f3_code = ALU_SLTU;
            3'b100:  f3_code = ALU_XOR;
            3'b101:  f3_code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f3_code = ALU_OR;
            default: f3_code = ALU_AND;
        endcase
    end

    always_comb begin
        dec = RESET_ENTRY;
        dec.illegal = 1'b1;
        case (opcode)
            OPC_OP: if (f7_ok_op) begin
                dec = '{alucode: f3_code, op1: rs1Data, op2: rs2Data, default: '0};
            end
            OPC_OPIMM: if (!is_shift || f7_ok_shift) begin
                dec = '{alucode: f3_code, op1: rs1Data, default: '0};
                dec.op2 = is_shift ? {{(XLEN-5){1'b0}}, ifInsn[24:20]} : imm_i;
            end
            OPC_LUI:   dec = '{alucode: ALU_ADD, op2: imm_u, default: '0};
            OPC_AUIPC: dec = '{alucode: ALU_ADD, op1: ifPc, op2: imm_u, default: '0};
            OPC_JAL:   dec = '{alucode: ALU_JUMP, op2: ifPc, default: '0};
            OPC_JALR: if (funct3 == 3'b000) begin
                dec = '{alucode: ALU_JUMP, op2: ifPc, default: '0};
            end
            default: ;
        endcase
        dec.rd = ifInsn[11:7];
        dec.reg_write = !dec.illegal && dec.rd != 5'd0;
    end

    assign in_fire   = ifValid && ifReady;
    assign out_fire  = main_valid && exReady;
    assign main_free = !main_valid || out_fire;
    // skid_valid is a flop, so ready never depends combinationally on exReady
    assign ifReady   = !skid_valid;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= RESET_ENTRY;
            skid_q     <= RESET_ENTRY;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            main_valid <= skid_valid || in_fire;
            skid_valid <= skid_valid && in_fire;
            if (skid_valid) main_q <= skid_q;
            else if (in_fire) main_q <= dec;
            if (skid_valid && in_fire) skid_q <= dec;
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_q     <= dec;
        end
    end

    assign exValid    = main_valid;
    assign exAlucode  = main_q.alucode;
    assign exOp1      = main_q.op1;
    assign exOp2      = main_q.op2;
    assign exRd       = main_q.rd;
    assign exRegWrite = main_q.reg_write;
    assign exIllegal  = main_q.illegal;
endmodule

// File: tb/tb_int_decode_stage.sv
// tb_int_decode_stage: directed decode vectors checked through an expected-response queue,
// plus backpressure, flush and asynchronous reset scenarios.
module tb_int_decode_stage;
    logic        clk = 1'b0, rstN = 1'b0, flush = 1'b0, ifValid = 1'b0, exReady = 1'b0;
    logic        ifReady, exValid, exRegWrite, exIllegal;
    logic [31:0] ifPc = '0, ifInsn = '0, rs1Data = '0, rs2Data = '0, exOp1, exOp2;
    logic [4:0]  rs1Addr, rs2Addr, exRd;
    logic [3:0]  exAlucode;
    int          checks = 0, failures = 0, pops = 0;
    logic [74:0] sb[$];
    logic [74:0] ex_bus;

    int_decode_stage dut (
        .clk(clk), .rstN(rstN), .flush(flush), .ifValid(ifValid), .ifReady(ifReady),
        .ifPc(ifPc), .ifInsn(ifInsn), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
        .rs1Data(rs1Data), .rs2Data(rs2Data), .exValid(exValid), .exReady(exReady),
        .exAlucode(exAlucode), .exOp1(exOp1), .exOp2(exOp2), .exRd(exRd),
        .exRegWrite(exRegWrite), .exIllegal(exIllegal)
    );

    always #5 clk = ~clk;
    assign ex_bus = {exAlucode, exOp1, exOp2, exRd, exRegWrite, exIllegal};

    function automatic logic [74:0] mk(input logic [3:0] a, input logic [31:0] o1, input logic [31:0] o2,
                                       input logic [4:0] rd, input logic rw, input logic ill);
        return {a, o1, o2, rd, rw, ill};
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstN && exValid && exReady) begin
            pops++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output got=%h exp=none", ex_bus);
            end else begin
                chk("scoreboard", {5'b0, ex_bus}, {5'b0, sb.pop_front()});
            end
        end
    end

    task automatic send(input logic [31:0] insn, input logic [31:0] pc, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [74:0] exp);
        int n = 0;
        ifValid = 1'b1; ifInsn = insn; ifPc = pc; rs1Data = r1; rs2Data = r2;
        @(negedge clk);
        while (!ifReady && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("send_ready", {79'b0, ifReady}, 80'd1);
        chk("rs1_addr", {75'b0, rs1Addr}, {75'b0, insn[19:15]});
        chk("rs2_addr", {75'b0, rs2Addr}, {75'b0, insn[24:20]});
        if (ifReady) sb.push_back(exp);
        @(posedge clk); #1;
        ifValid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_exvalid"}, {79'b0, exValid}, 80'd0);
        chk({tag, "_ifready"}, {79'b0, ifReady}, 80'd1);
        chk({tag, "_outputs"}, {5'b0, ex_bus}, {5'b0, mk(4'hF, 0, 0, 0, 0, 0)});
    endtask

    task automatic drain(input string tag);
        repeat (6) @(negedge clk);
        chk({tag, "_drained"}, 80'(sb.size()), 80'd0);
        @(posedge clk); #1;
    endtask

    localparam logic [31:0] I_A = 32'h00500093, I_B = 32'h402081B3, I_C = 32'h123453B7;
    logic [74:0] e_a, e_b, e_c;
    int p0;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        e_a = mk(4'd0, 32'h0, 32'h5, 5'd1, 1'b1, 1'b0);
        e_b = mk(4'd1, 32'h10, 32'h3, 5'd3, 1'b1, 1'b0);
        e_c = mk(4'd0, 32'h0, 32'h12345000, 5'd7, 1'b1, 1'b0);
        exReady = 1'b1;
        #12 check_idle("reset");
        @(posedge clk); #1 rstN = 1'b1;

        send(I_A, 32'h0, 32'h0, 32'h0, e_a);
        send(32'h40335293, 32'h0, 32'h80000000, 32'h0, mk(4'd9, 32'h80000000, 32'h3, 5'd5, 1'b1, 1'b0));
        send(I_B, 32'h0, 32'h10, 32'h3, e_b);
        send(I_C, 32'h0, 32'hdead, 32'h0, e_c);
        send(32'h000000EF, 32'h100, 32'h0, 32'h0, mk(4'd10, 32'h0, 32'h100, 5'd1, 1'b1, 1'b0));
        send(32'h0000007F, 32'h0, 32'h1, 32'h2, mk(4'd15, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1));
        send(32'h00000013, 32'h0, 32'h55, 32'h0, mk(4'd0, 32'h55, 32'h0, 5'd0, 1'b0, 1'b0));
        send(32'h00001117, 32'h200, 32'h7, 32'h0, mk(4'd0, 32'h200, 32'h1000, 5'd2, 1'b1, 1'b0));
        send(32'h023100B3, 32'h0, 32'h1, 32'h2, mk(4'd15, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1));
        send(32'h40109093, 32'h0, 32'h1, 32'h0, mk(4'd15, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1));
        send(32'h000100E7, 32'h300, 32'h9, 32'h0, mk(4'd10, 32'h0, 32'h300, 5'd1, 1'b1, 1'b0));
        send(32'h000110E7, 32'h300, 32'h9, 32'h0, mk(4'd15, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1));
        send(32'hFFF0F213, 32'h0, 32'h1234, 32'h0, mk(4'd6, 32'h1234, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b0));
        send(32'hFFF00093, 32'h0, 32'h0, 32'h0, mk(4'd0, 32'h0, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0));
        send(32'h003150B3, 32'h0, 32'hF0, 32'h4, mk(4'd8, 32'hF0, 32'h4, 5'd1, 1'b1, 1'b0));
        drain("decode");

        exReady = 1'b0;
        send(I_A, 32'h0, 32'h0, 32'h0, e_a);
        send(I_B, 32'h0, 32'h10, 32'h3, e_b);
        ifValid = 1'b1; ifInsn = I_C; rs1Data = 32'hdead; rs2Data = 32'h0;
        @(negedge clk);
        chk("bp_ifready_low", {79'b0, ifReady}, 80'd0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_exvalid_held", {79'b0, exValid}, 80'd1);
            chk("bp_ex_stable", {5'b0, ex_bus}, {5'b0, e_a});
            @(negedge clk);
        end
        @(posedge clk); #1 exReady = 1'b1;
        send(I_C, 32'h0, 32'hdead, 32'h0, e_c);
        drain("bp");
        chk("bp_ifready_back", {79'b0, ifReady}, 80'd1);

        exReady = 1'b0;
        send(I_A, 32'h0, 32'h0, 32'h0, e_a);
        send(I_B, 32'h0, 32'h10, 32'h3, e_b);
        flush = 1'b1; ifValid = 1'b1; ifInsn = I_C; rs1Data = 32'hdead;
        @(posedge clk); #1 flush = 1'b0; ifValid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_exvalid", {79'b0, exValid}, 80'd0);
        chk("flush_ifready", {79'b0, ifReady}, 80'd1);
        @(posedge clk); #1 exReady = 1'b1;
        p0 = pops;
        flush = 1'b1; ifValid = 1'b1; ifInsn = I_A; rs1Data = 32'h0;
        @(posedge clk); #1 flush = 1'b0; ifValid = 1'b0;
        repeat (5) @(negedge clk);
        chk("flush_no_output", 80'(pops - p0), 80'd0);
        @(posedge clk); #1;
        send(I_B, 32'h0, 32'h10, 32'h3, e_b);
        drain("post_flush");

        exReady = 1'b0;
        send(I_A, 32'h0, 32'h0, 32'h0, e_a);
        send(I_C, 32'h0, 32'hdead, 32'h0, e_c);
        #2 rstN = 1'b0;
        #1 check_idle("async_reset");
        sb.delete();
        @(posedge clk); #1 rstN = 1'b1; exReady = 1'b1;
        send(I_B, 32'h0, 32'h10, 32'h3, e_b);
        drain("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/int_decode_stage.md
Name: int_decode_stage

Overview:
- Decode stage that produces the operands for the integer ALU in the execute stage: alucode, op1 and op2.
- Takes fetched RV32I instructions with their PC and decodes integer/jump/upper-immediate ops into alucode, op1, op2 and writeback info.
- Output is registered, with a valid/ready handshake and a 2-entry skid buffer, so execute-stage stalls never create a combinational ready path back into fetch.

Parameters:
- XLEN, 32, data/PC width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rstN  in  1  reset, asynchronous, active-low
- flush  in  1  discard all held and incoming instructions
- ifValid  in  1  fetch presents an instruction
- ifReady  out  1  stage can accept; registered
- ifPc  in  32  instruction PC
- ifInsn  in  32  instruction word
- rs1Addr  out  5  register-file read address, combinational = ifInsn[19:15]
- rs2Addr  out  5  register-file read address, combinational = ifInsn[24:20]
- rs1Data  in  32  register-file data, same cycle as rs1Addr
- rs2Data  in  32  register-file data, same cycle as rs2Addr
- exValid  out  1  decoded op valid
- exReady  in  1  execute accepts
- exAlucode  out  4  ALU operation
- exOp1  out  32  ALU operand 1
- exOp2  out  32  ALU operand 2
- exRd  out  5  destination register
- exRegWrite  out  1  write exRd (0 when rd==0)
- exIllegal  out  1  opcode/funct not supported

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Alucode values (package constants): ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9, JUMP=10, NONE=15.
- OP (0110011):
  - op1=rs1Data, op2=rs2Data.
  - funct7 must be 0000000, except 0100000 with funct3 000 (SUB) or 101 (SRA).
  - funct3 map: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
- OP-IMM (0010011):
  - op1=rs1Data, op2=sign-extended insn[31:20]; same funct3 map.
  - Shifts: op2 = zero-extended shamt insn[24:20]. insn[31:25] must be 0000000, or 0100000 for SRAI; otherwise illegal.
- LUI: ADD, op1=0, op2={insn[31:12],12'b0}.
- AUIPC: ADD, op1=ifPc, op2={insn[31:12],12'b0}.
- JAL, JALR (funct3=000): JUMP, op1=0, op2=ifPc, so the ALU result is the link address PC+4.
- Anything else:
  - exAlucode=NONE, op1=op2=0, exRegWrite=0, exIllegal=1.
  - Still passes through the handshake.
- exRd=insn[11:7]; exRegWrite=legal && rd!=0.
- Transfers: input transfer = ifValid&&ifReady; output transfer = exValid&&exReady.
- Latency: 1 cycle. An accepted instruction appears on ex* the next cycle when the main register is free.
- Storage:
  - Main register drives ex*.
  - Skid register holds one overflow entry. An entry is written to skid when an input is accepted while main is valid and not draining.
  - When main drains and skid is valid, skid moves to main the same edge. If an input is accepted in that cycle, it refills skid.
- ifReady is registered: next ifReady = !(skid valid next). Fetch must not rely on a combinational response.
- Ordering is strict FIFO; exValid is never dropped while exReady=0 and ex* hold stable.
- Flush:
  - Next edge clears both valids; an input presented in the flush cycle is discarded.
  - ifReady=1 next cycle.
  - Flush takes priority over all simultaneous transfers.
- Reset values: exValid=0, ifReady=1, exAlucode=NONE, exOp1=exOp2=0, exRd=0, exRegWrite=0, exIllegal=0; skid empty.
- Reset mid-operation discards all entries immediately (asynchronous assertion); deassertion is synchronous.

Test Plan:
- After reset, ifValid=1, ifInsn=0x00500093 (addi x1,x0,5), rs1Data=0, exReady=1 -> next cycle exValid=1, exAlucode=0, exOp1=0, exOp2=5, exRd=1, exRegWrite=1.
- Shift and subtract decode:
  - ifInsn=0x40335293 (srai x5,x6,3), rs1Data=0x80000000 -> exAlucode=9, exOp2=3.
  - ifInsn=0x402081B3 (sub x3,x1,x2) -> exAlucode=1, op1/op2=rs1Data/rs2Data.
- Upper-immediate and jump decode:
  - ifInsn=0x123453B7 (lui x7,0x12345) -> exOp1=0, exOp2=0x12345000, alucode 0.
  - jal x1 at ifPc=0x100 -> alucode 10, exOp2=0x100.
- Illegal and rd=0 handling:
  - ifInsn=0x0000007F -> exIllegal=1, exAlucode=15, exRegWrite=0.
  - addi x0 (0x00000013) -> exRegWrite=0, exIllegal=0.
- Backpressure: hold exReady=0, stream 3 instructions -> 2 accepted, ifReady=0 the cycle after the second; ex* stable. Release exReady -> outputs appear in order, ifReady returns to 1.
- Flush and reset:
  - With both entries full, assert flush together with ifValid -> next cycle exValid=0, ifReady=1, and the third instruction never appears.
  - Assert rstN=0 mid-stream -> outputs go to reset values without waiting for a clock edge.
